// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider: operand width,
// iteration count, result packing offsets, FSM state encoding and a small
// absolute-value helper.
package div_pkg;

  localparam int DIV_W     = 32;
  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = $clog2(DIV_ITERS);
  localparam int RES_W     = 2 * DIV_W;

  // Result packing: {quotient, remainder}
  localparam int Q_LSB = DIV_W;
  localparam int R_LSB = 0;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    PREP,
    ITER,
    FIX,
    DONE
  } state_t;

  // Magnitude of an operand; unsigned operands pass through untouched.
  // 0x80000000 in signed mode maps to 0x80000000, which is the correct
  // unsigned magnitude.
  function automatic logic [DIV_W-1:0] abs_val(input logic [DIV_W-1:0] x,
                                               input logic is_signed);
    return (is_signed && x[DIV_W-1]) ? -x : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder, trial-subtract the divisor and keep the
// difference only if it did not go negative.
module div_step
  import div_pkg::*;
(
  input  logic [DIV_W:0]   rem,
  input  logic [DIV_W-1:0] divisor,
  input  logic             dvd_bit,
  output logic [DIV_W:0]   rem_next,
  output logic             q_bit
);

  logic [DIV_W+1:0] shifted;
  logic [DIV_W+1:0] diff;

  // Trial subtraction; the top bit of diff is the borrow.
  always_comb begin
    shifted  = {rem, dvd_bit};
    diff     = shifted - {2'b00, divisor};
    q_bit    = ~diff[DIV_W+1];
    rem_next = q_bit ? diff[DIV_W:0] : shifted[DIV_W:0];
  end

endmodule

// File: rtl/div_iter_core.sv
// Iterative radix-2 restoring divider with independent dividend/divisor
// stream channels and a one-cycle 64-bit result strobe {quotient, remainder}.
// Optional feature macro: DIV_EARLY_OUT_EN (PREP skips the iterations when
// the divisor is zero or |dividend| < |divisor|).
//
// Handshake: a channel transfers on a rising edge where tvalid && tready.
// tready is high only while the FSM is in IDLE/WAIT and that channel's slot
// is empty; a full slot never re-accepts. The result channel has no ready:
// dout_tvalid pulses for exactly one cycle and dout_tdata holds until the
// next result is produced.
module div_iter_core
  import div_pkg::*;
(
  input  logic             div_clk,
  input  logic             div_resetn,
  input  logic             div_signed,
  input  logic [DIV_W-1:0] div_dividend_tdata,
  input  logic             div_dividend_tvalid,
  output logic             div_dividend_tready,
  input  logic [DIV_W-1:0] div_divisor_tdata,
  input  logic             div_divisor_tvalid,
  output logic             div_divisor_tready,
  output logic             div_dout_tvalid,
  output logic [RES_W-1:0] div_dout_tdata,
  output state_t           div_state
);

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_ITERS - 1);

  state_t             state;
  logic               started;
  logic               dvd_full;
  logic               dvs_full;
  logic [DIV_W-1:0]   dvd_r;
  logic [DIV_W-1:0]   dvs_r;
  logic               signed_r;
  logic               q_neg;
  logic               r_neg;
  logic [DIV_W-1:0]   dvs_abs;
  logic [DIV_W-1:0]   q_sh;
  logic [DIV_W:0]     rem;
  logic [CNT_W-1:0]   cnt;

  logic               dvd_fire;
  logic               dvs_fire;
  logic               dvd_full_n;
  logic               dvs_full_n;
  logic [DIV_W-1:0]   dvd_abs_c;
  logic [DIV_W-1:0]   dvs_abs_c;
  logic               early_hit;
  logic [DIV_W:0]     rem_next;
  logic               q_bit;
  logic [DIV_W-1:0]   q_fix;
  logic [DIV_W-1:0]   r_fix;
  logic [RES_W-1:0]   fix_res;

  // Slots accept only while collecting operands; started keeps tready low
  // until the first edge after reset release.
  assign div_dividend_tready = started && !dvd_full && (state == IDLE || state == WAIT);
  assign div_divisor_tready  = started && !dvs_full && (state == IDLE || state == WAIT);
  assign dvd_fire   = div_dividend_tvalid && div_dividend_tready;
  assign dvs_fire   = div_divisor_tvalid && div_divisor_tready;
  assign dvd_full_n = dvd_full || dvd_fire;
  assign dvs_full_n = dvs_full || dvs_fire;
  assign div_state  = state;

  // Operand magnitudes and the early-out condition, evaluated during PREP.
  always_comb begin
    dvd_abs_c = abs_val(dvd_r, signed_r);
    dvs_abs_c = abs_val(dvs_r, signed_r);
    early_hit = (dvs_r == '0) || (dvd_abs_c < dvs_abs_c);
  end

  div_step u_step (
    .rem      (rem),
    .divisor  (dvs_abs),
    .dvd_bit  (q_sh[DIV_W-1]),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // Sign fix-up and result packing; a zero divisor bypasses the sign fix.
  always_comb begin
    q_fix = q_neg ? -q_sh : q_sh;
    r_fix = r_neg ? -rem[DIV_W-1:0] : rem[DIV_W-1:0];
    if (dvs_r == '0) begin
      q_fix = '1;
      r_fix = dvd_r;
    end
    fix_res = '0;
    fix_res[Q_LSB +: DIV_W] = q_fix;
    fix_res[R_LSB +: DIV_W] = r_fix;
  end

  // Control FSM and datapath registers.
  always_ff @(posedge div_clk or negedge div_resetn) begin
    if (!div_resetn) begin
      state           <= IDLE;
      started         <= 1'b0;
      dvd_full        <= 1'b0;
      dvs_full        <= 1'b0;
      dvd_r           <= '0;
      dvs_r           <= '0;
      signed_r        <= 1'b0;
      q_neg           <= 1'b0;
      r_neg           <= 1'b0;
      dvs_abs         <= '0;
      q_sh            <= '0;
      rem             <= '0;
      cnt             <= '0;
      div_dout_tvalid <= 1'b0;
      div_dout_tdata  <= '0;
    end else begin
      started         <= 1'b1;
      div_dout_tvalid <= 1'b0;
      case (state)
        IDLE, WAIT: begin
          if (dvd_fire) begin
            dvd_r    <= div_dividend_tdata;
            signed_r <= div_signed;
          end
          if (dvs_fire) begin
            dvs_r <= div_divisor_tdata;
          end
          dvd_full <= dvd_full_n;
          dvs_full <= dvs_full_n;
          if (dvd_full_n && dvs_full_n) begin
            state <= PREP;
          end else if (dvd_full_n || dvs_full_n) begin
            state <= WAIT;
          end else begin
            state <= IDLE;
          end
        end
        PREP: begin
          dvd_full <= 1'b0;
          dvs_full <= 1'b0;
          q_neg    <= signed_r && (dvd_r[DIV_W-1] ^ dvs_r[DIV_W-1]);
          r_neg    <= signed_r && dvd_r[DIV_W-1];
          dvs_abs  <= dvs_abs_c;
          cnt      <= '0;
          if (EARLY_OUT && early_hit) begin
            q_sh  <= '0;
            rem   <= {1'b0, dvd_abs_c};
            state <= FIX;
          end else begin
            q_sh  <= dvd_abs_c;
            rem   <= '0;
            state <= ITER;
          end
        end
        ITER: begin
          // Dividend bits shift out of the top of q_sh as quotient bits
          // shift in at the bottom.
          q_sh <= {q_sh[DIV_W-2:0], q_bit};
          rem  <= rem_next;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == LAST_STEP) begin
            state <= FIX;
          end
        end
        FIX: begin
          div_dout_tdata <= fix_res;
          state          <= DONE;
        end
        DONE: begin
          div_dout_tvalid <= 1'b1;
          state           <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter_core.sv
// Self-checking bench for div_iter_core: directed corner cases, randomized
// operands with random channel skew, mid-operation reset and back-to-back
// throughput with held tvalid. Results and strobe timing are predicted from
// plain integer arithmetic.
module tb_div_iter_core;
  import div_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        div_signed;
  logic [31:0] dvd_data;
  logic        dvd_valid;
  logic        dvd_tready;
  logic [31:0] dvs_data;
  logic        dvs_valid;
  logic        dvs_tready;
  logic        dout_tvalid;
  logic [63:0] dout_tdata;
  state_t      dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_cnt = 0;
  logic [63:0] exp_q[$];
  int          exp_e_q[$];

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY_MODEL = 1'b1;
`else
  localparam bit EARLY_MODEL = 1'b0;
`endif

  div_iter_core dut (
    .div_clk             (clk),
    .div_resetn          (rst_n),
    .div_signed          (div_signed),
    .div_dividend_tdata  (dvd_data),
    .div_dividend_tvalid (dvd_valid),
    .div_dividend_tready (dvd_tready),
    .div_divisor_tdata   (dvs_data),
    .div_divisor_tvalid  (dvs_valid),
    .div_divisor_tready  (dvs_tready),
    .div_dout_tvalid     (dout_tvalid),
    .div_dout_tdata      (dout_tdata),
    .div_state           (dbg_state)
  );

  // Clock and edge counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer division semantics.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input bit s);
    int sa, sb, q, r;
    if (b == 0) return {32'hFFFF_FFFF, a};
    if (!s) return {a / b, a % b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
    sa = $signed(a);
    sb = $signed(b);
    q  = sa / sb;
    r  = sa % sb;
    return {q, r};
  endfunction

  function automatic longint mag(input logic [31:0] x, input bit s);
    longint v;
    v = s ? longint'($signed(x)) : longint'({32'h0, x});
    return (v < 0) ? -v : v;
  endfunction

  function automatic int latency(input logic [31:0] a, input logic [31:0] b, input bit s);
    if (EARLY_MODEL && (b == 0 || mag(a, s) < mag(b, s))) return 3;
    return 35;
  endfunction

  task automatic push_exp(input logic [31:0] a, input logic [31:0] b, input bit s,
                          input int e0);
    exp_q.push_back(ref_div(a, b, s));
    exp_e_q.push_back(e0 + latency(a, b, s));
  endtask

  // Scoreboard: every strobe must match the oldest expected result and edge.
  always @(negedge clk) begin
    if (dout_tvalid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_strobe", 64'(dout_tvalid), 64'h0);
      end else begin
        chk("dout_tdata", dout_tdata, exp_q.pop_front());
        chk("strobe_edge", 64'(edge_cnt), 64'(exp_e_q.pop_front()));
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!(dvd_tready && dvs_tready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("idle_timeout", 64'(n), 64'h0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      chk("done_timeout", 64'(exp_q.size()), 64'h0);
      exp_q.delete();
      exp_e_q.delete();
    end
  endtask

  // skew > 0: divisor arrives skew edges after the dividend; skew < 0: the
  // divisor leads. The early channel keeps tvalid high with junk data to
  // show that a full slot does not re-accept.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit s,
                        input int skew);
    int gap;
    wait_idle();
    if (skew == 0) begin
      div_signed = s; dvd_data = a; dvs_data = b;
      dvd_valid = 1'b1; dvs_valid = 1'b1;
      @(posedge clk); @(negedge clk);
    end else if (skew > 0) begin
      div_signed = s; dvd_data = a; dvd_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      dvd_data = $urandom; div_signed = 1'($urandom_range(0, 1));
      gap = skew;
      for (int i = 0; i < gap; i++) begin
        chk("dvd_ready_wait", 64'(dvd_tready), 64'h0);
        chk("dvs_ready_wait", 64'(dvs_tready), 64'h1);
        if (i < gap - 1) @(negedge clk);
      end
      dvs_data = b; dvs_valid = 1'b1;
      @(posedge clk); @(negedge clk);
    end else begin
      div_signed = 1'($urandom_range(0, 1)); dvs_data = b; dvs_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      dvs_data = $urandom;
      gap = -skew;
      for (int i = 0; i < gap; i++) begin
        chk("dvs_ready_wait", 64'(dvs_tready), 64'h0);
        chk("dvd_ready_wait", 64'(dvd_tready), 64'h1);
        if (i < gap - 1) @(negedge clk);
      end
      div_signed = s; dvd_data = a; dvd_valid = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    dvd_valid = 1'b0; dvs_valid = 1'b0;
    div_signed = 1'($urandom_range(0, 1));
    push_exp(a, b, s, edge_cnt);
  endtask

  initial begin
    int e0, e1, n, skew;
    logic [31:0] a, b;
    bit s;

    rst_n = 1'b0; div_signed = 1'b0;
    dvd_data = '0; dvd_valid = 1'b0; dvs_data = '0; dvs_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", 64'(dout_tvalid), 64'h0);
    chk("rst_tdata", dout_tdata, 64'h0);
    chk("rst_dvd_ready", 64'(dvd_tready), 64'h0);
    chk("rst_dvs_ready", 64'(dvs_tready), 64'h0);
    rst_n = 1'b1;
    #1;
    chk("rel_dvd_ready_pre", 64'(dvd_tready), 64'h0);
    @(negedge clk);
    chk("rel_dvd_ready", 64'(dvd_tready), 64'h1);
    chk("rel_dvs_ready", 64'(dvs_tready), 64'h1);

    // Directed corners
    run_op(32'd100, 32'd7, 1'b0, 0);                  wait_done();
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 3);            wait_done();
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);    wait_done();
    run_op(32'h1234_5678, 32'h0, 1'b0, -2);           wait_done();
    run_op(32'hFFFF_FFFB, 32'h0, 1'b1, 1);            wait_done();
    run_op(32'd3, 32'd10, 1'b0, 0);                   wait_done();
    run_op(32'h7FFF_FFFF, 32'd1, 1'b0, 0);            wait_done();
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, -1);           wait_done();

    // Randomized operands, mode and channel skew
    for (int k = 0; k < 24; k++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom_range(0, 15);
        1:       b = $urandom >> $urandom_range(0, 31);
        2:       b = -($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      s    = 1'($urandom_range(0, 1));
      skew = $urandom_range(0, 6) - 3;
      run_op(a, b, s, skew);
      wait_done();
    end

    // Reset in the middle of an operation: no strobe may follow.
    run_op(32'd1234567, 32'd89, 1'b0, 0);
    e0 = edge_cnt;
    while (edge_cnt < e0 + 10) @(negedge clk);
    exp_q.delete();
    exp_e_q.delete();
    rst_n = 1'b0;
    #1;
    chk("midrst_tvalid", 64'(dout_tvalid), 64'h0);
    chk("midrst_dvd_ready", 64'(dvd_tready), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    run_op(32'd9, 32'd3, 1'b0, 0);
    wait_done();

    // Held tvalid: accepts exactly at E0 and E36.
    wait_idle();
    div_signed = 1'b0; dvd_data = 32'hF000_0000; dvs_data = 32'd1;
    dvd_valid = 1'b1; dvs_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    e0 = edge_cnt;
    push_exp(32'hF000_0000, 32'd1, 1'b0, e0);
    dvd_data = 32'd1000; dvs_data = 32'd33;
    n = 0;
    while (!(dvd_tready && dvs_tready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("held_accept_edge", 64'(edge_cnt + 1), 64'(e0 + 36));
    @(posedge clk); @(negedge clk);
    e1 = edge_cnt;
    dvd_valid = 1'b0; dvs_valid = 1'b0;
    push_exp(32'd1000, 32'd33, 1'b0, e1);
    wait_done();

    repeat (5) @(negedge clk);
    chk("final_queue_empty", 64'(exp_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_iter_core.md
# div_iter_core

Native iterative radix-2 restoring divider implementing the responder (slave) side of the CPU's AXI-stream-style divide interface: separate dividend and divisor channels, a signed/unsigned select, and a 64-bit result channel. It drops in behind the EXE-stage divide issue logic as a vendor-IP-free replacement for the signed and unsigned divider cores, with identical port semantics and result packing.

## Interface
- DIV_W, 32, operand width; the result is 2*DIV_W.
- div_clk  in  1  clock; all state updates on the rising edge.
- div_resetn  in  1  reset, asynchronous, active-low.
- div_signed  in  1  1 = signed (two's complement), 0 = unsigned; sampled on dividend acceptance.
- div_dividend_tdata  in  32  dividend.
- div_dividend_tvalid  in  1  dividend valid.
- div_dividend_tready  out  1  dividend slot can accept.
- div_divisor_tdata  in  32  divisor.
- div_divisor_tvalid  in  1  divisor valid.
- div_divisor_tready  out  1  divisor slot can accept.
- div_dout_tvalid  out  1  one-cycle result strobe; no backpressure.
- div_dout_tdata  out  64  {quotient[63:32], remainder[31:0]}.

## Operation
- A channel transfers on a rising edge with tvalid&tready. The two channels are independent; either may arrive first, and both may arrive on the same edge.
- States:
  - IDLE: both slots empty.
  - WAIT: exactly one slot full.
  - PREP: take absolute values; set signs q_neg = sd^sv and r_neg = sd (signed mode only).
  - ITER: 32 restoring steps, one quotient bit per cycle, MSB first, on a 33-bit partial remainder.
  - FIX: negate quotient/remainder per sign flags; register dout_tdata.
  - DONE: dout_tvalid=1, then back to IDLE.
- Transitions: IDLE→WAIT on one transfer. IDLE→PREP on both. WAIT→PREP when the missing channel arrives. PREP→ITER. ITER→FIX after the 32nd step. FIX→DONE→IDLE.
- tready for a channel is 1 only when its slot is empty and state ∈ {IDLE, WAIT}. A slot that is already full does not re-accept.
- Divisor zero: quotient=0xFFFFFFFF, remainder=dividend. This holds in both modes and is not sign-fixed.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0.
- Remainder sign follows the dividend; the quotient truncates toward zero.
- div_signed is latched with the dividend. A change afterwards has no effect on the operation in flight.

## Timing
- Reset values: dout_tvalid=0, dout_tdata=0, both tready=0 while div_resetn=0. tready rises on the first edge after deassertion; state=IDLE, slots empty.
- Latency: with the completing transfer on edge E0, dout_tvalid is high from E35 to E36, for exactly one cycle.
- dout_tdata is stable from E35 until the next FIX update.
- Throughput: one operation per 36 cycles. A new transfer is accepted earliest on E36, while in IDLE.
- Reset asserted mid-operation: aborts immediately with no dout_tvalid strobe; slots are cleared and an operand captured in WAIT is discarded.
- An unaccepted tvalid held across DONE is accepted on the IDLE edge that follows.

## Configuration
- DIV_EARLY_OUT_EN defined: PREP detects divisor==0 or |dividend|<|divisor| and goes directly to FIX (quotient=0 or all-ones, remainder=dividend). dout_tvalid then comes at E3. Otherwise timing is unchanged.
- Undefined: every operation takes the fixed 35-cycle latency.

## Structure
- Package div_pkg holds the state enum (IDLE, WAIT, PREP, ITER, FIX, DONE), DIV_W, the iteration count DIV_ITERS=32, and the result-packing bit offsets.
- Sub-module div_step: a combinational single restoring step. Inputs are the partial remainder, divisor and next dividend bit; outputs are the next partial remainder and the quotient bit. It is instantiated once and used iteratively.

## Test plan
- Unsigned 100/7, both channels on the same edge → dout 0x0000000E_00000002 at E35, exactly one strobe.
- Signed -7/2, divisor 3 cycles after the dividend → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; dividend_tready low while waiting.
- Signed 0x80000000/0xFFFFFFFF → 0x80000000_00000000. Unsigned 0x12345678/0 → 0xFFFFFFFF_12345678.
- Reset pulsed at E10 of an operation → no dout_tvalid; after release, 9/3 gives 0x00000003_00000000 at the correct latency.
- tvalid held continuously with new operands → accepts at E0 and E36 only; strobes at E35 and E71.
- With DIV_EARLY_OUT_EN: 3/10 unsigned → 0x00000000_00000003 at E3. 0x7FFFFFFF/1 still at E35.
